// File: rtl/verilog_literal_emitter_pkg.sv
// Shared types and constants for the Verilog literal emitter.
// State list, base codes, ASCII constants and digit-to-char helper.
package verilog_lit_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SIZE_T,
    S_SIZE_O,
    S_TICK,
    S_SGN,
    S_BASE,
    S_DIGIT
`ifdef VERILOG_LITERAL_SEP_EN
    , S_SEP
`endif
  } state_e;

  localparam logic [1:0] BASE_B = 2'd0;
  localparam logic [1:0] BASE_O = 2'd1;
  localparam logic [1:0] BASE_H = 2'd2;

  localparam logic [7:0] CH_TICK = 8'h27;
  localparam logic [7:0] CH_SEP  = 8'h5f;
  localparam logic [7:0] CH_S    = 8'h73;
  localparam logic [7:0] CH_B    = 8'h62;
  localparam logic [7:0] CH_O    = 8'h6f;
  localparam logic [7:0] CH_H    = 8'h68;

  function automatic logic [7:0] nibble_to_ascii(
    input logic [3:0] n
  );
    return (n < 4'd10) ? (8'h30 + {4'h0, n})
                       : (8'h57 + {4'h0, n});
  endfunction

endpackage

// File: rtl/verilog_literal_emitter_if.sv
// Request and character-stream handshake bundle.
// slave = emitter side, master = value source / char sink side.
interface verilog_literal_emitter_if #(
  parameter int W_DATA = 32
);
  localparam int W_LEN = $clog2(W_DATA + 1);

  logic              i_valid;
  logic              o_ready;
  logic [W_DATA-1:0] i_value;
  logic [W_LEN-1:0]  i_width;
  logic [1:0]        i_base;
  logic              i_signed;
  logic              o_char_valid;
  logic              i_char_ready;
  logic [7:0]        o_char;
  logic              o_char_last;
  logic              o_busy;

  modport slave (
    input  i_valid, i_value, i_width,
    input  i_base, i_signed, i_char_ready,
    output o_ready, o_char_valid, o_char,
    output o_char_last, o_busy
  );

  modport master (
    output i_valid, i_value, i_width,
    output i_base, i_signed, i_char_ready,
    input  o_ready, o_char_valid, o_char,
    input  o_char_last, o_busy
  );

endinterface

// File: rtl/verilog_literal_emitter_digit_sel.sv
// Extracts digit idx_i of a value in base 2/8/16,
// zeroing bits at or above the effective width.
module lit_digit_sel #(
  parameter  int W_DATA = 32,
  localparam int W_LEN  = $clog2(W_DATA + 1)
) (
  input  logic [W_DATA-1:0] value_i,
  input  logic [W_LEN-1:0]  width_i,
  input  logic [1:0]        base_i,
  input  logic [W_LEN-1:0]  idx_i,
  output logic [3:0]        digit_o
);
  import verilog_lit_pkg::*;

  logic [W_DATA-1:0] mask;
  logic [W_DATA+3:0] ext;
  logic [W_LEN+1:0]  shamt;
  logic [3:0]        kmask;

  always_comb begin
    // shifting by the full width yields 0, so mask becomes all ones
    mask = ~({W_DATA{1'b1}} << width_i);
    ext  = {4'h0, value_i & mask};
    unique case (1'b1)
      base_i[1]: begin
        shamt = {idx_i, 2'b00};
        kmask = 4'hf;
      end
      base_i == BASE_O: begin
        shamt = {2'b00, idx_i} + {1'b0, idx_i, 1'b0};
        kmask = 4'h7;
      end
      default: begin
        shamt = {2'b00, idx_i};
        kmask = 4'h1;
      end
    endcase
    digit_o = 4'(ext >> shamt) & kmask;
  end

endmodule

// File: rtl/verilog_literal_emitter.sv
// Streams a value as a sized Verilog literal, one char per cycle.
// Define VERILOG_LITERAL_SEP_EN to insert '_' every 4 digits.
module verilog_literal_emitter #(
  parameter int W_DATA = 32
) (
  input logic                     i_clk,
  input logic                     i_reset,
  verilog_literal_emitter_if.slave bus
);
  import verilog_lit_pkg::*;

  localparam int W_LEN = $clog2(W_DATA + 1);

  state_e            st_q, st_d;
  logic [W_DATA-1:0] val_q, val_d;
  logic [W_LEN-1:0]  w_q, w_d;
  logic [W_LEN-1:0]  idx_q, idx_d;
  logic [1:0]        base_q, base_d;
  logic              sgn_q, sgn_d;
  logic              vld_q, vld_d;
  logic [7:0]        ch_q, ch_d;
  logic              last_q, last_d;

  logic              fire;
  logic [W_LEN-1:0]  w_in;
  logic [7:0]        w8, wd8, dcnt;
  logic [3:0]        dig;

  assign fire = vld_q && bus.i_char_ready;
  assign w_in = (bus.i_width == '0 ||
                 bus.i_width > W_LEN'(W_DATA))
              ? W_LEN'(W_DATA) : bus.i_width;
  assign w8   = 8'(w_q);
  assign wd8  = 8'(w_d);

  always_comb begin
    unique case (1'b1)
      base_q[1]:         dcnt = (w8 + 8'd3) >> 2;
      base_q == BASE_O:  dcnt = (w8 + 8'd2) / 8'd3;
      default:           dcnt = w8;
    endcase
  end

  lit_digit_sel #(.W_DATA(W_DATA)) u_dsel (
    .value_i (val_q),
    .width_i (w_q),
    .base_i  (base_q),
    .idx_i   (idx_d),
    .digit_o (dig)
  );

  always_comb begin
    st_d   = st_q;
    val_d  = val_q;
    w_d    = w_q;
    idx_d  = idx_q;
    base_d = base_q;
    sgn_d  = sgn_q;
    unique case (st_q)
      S_IDLE: if (bus.i_valid) begin
        val_d  = bus.i_value;
        w_d    = w_in;
        base_d = bus.i_base;
        sgn_d  = bus.i_signed;
        st_d   = (8'(w_in) >= 8'd10) ? S_SIZE_T : S_SIZE_O;
      end
      S_SIZE_T: if (fire) st_d = S_SIZE_O;
      S_SIZE_O: if (fire) st_d = S_TICK;
      S_TICK:   if (fire) st_d = sgn_q ? S_SGN : S_BASE;
      S_SGN:    if (fire) st_d = S_BASE;
      S_BASE: if (fire) begin
        st_d  = S_DIGIT;
        idx_d = W_LEN'(dcnt - 8'd1);
      end
      S_DIGIT: if (fire) begin
        if (idx_q == '0) st_d = S_IDLE;
`ifdef VERILOG_LITERAL_SEP_EN
        else if (idx_q[1:0] == 2'b00) st_d = S_SEP;
`endif
        else idx_d = idx_q - W_LEN'(1);
      end
`ifdef VERILOG_LITERAL_SEP_EN
      S_SEP: if (fire) begin
        st_d  = S_DIGIT;
        idx_d = idx_q - W_LEN'(1);
      end
`endif
      default: st_d = S_IDLE;
    endcase
  end

  // output register is loaded with the char of the state being entered
  always_comb begin
    vld_d  = (st_d != S_IDLE);
    last_d = (st_d == S_DIGIT) && (idx_d == '0);
    ch_d   = ch_q;
    unique case (st_d)
      S_SIZE_T: ch_d = nibble_to_ascii(4'(wd8 / 8'd10));
      S_SIZE_O: ch_d = nibble_to_ascii(4'(wd8 % 8'd10));
      S_TICK:   ch_d = CH_TICK;
      S_SGN:    ch_d = CH_S;
      S_BASE: begin
        unique case (1'b1)
          base_q[1]:        ch_d = CH_H;
          base_q == BASE_O: ch_d = CH_O;
          default:          ch_d = CH_B;
        endcase
      end
      S_DIGIT:  ch_d = nibble_to_ascii(dig);
`ifdef VERILOG_LITERAL_SEP_EN
      S_SEP:    ch_d = CH_SEP;
`endif
      default:  ch_d = ch_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      st_q   <= S_IDLE;
      val_q  <= '0;
      w_q    <= '0;
      idx_q  <= '0;
      base_q <= BASE_B;
      sgn_q  <= 1'b0;
      vld_q  <= 1'b0;
      ch_q   <= 8'h00;
      last_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      val_q  <= val_d;
      w_q    <= w_d;
      idx_q  <= idx_d;
      base_q <= base_d;
      sgn_q  <= sgn_d;
      vld_q  <= vld_d;
      ch_q   <= ch_d;
      last_q <= last_d;
    end
  end

  assign bus.o_ready      = (st_q == S_IDLE);
  assign bus.o_busy       = (st_q != S_IDLE);
  assign bus.o_char_valid = vld_q;
  assign bus.o_char       = ch_q;
  assign bus.o_char_last  = last_q;

endmodule

// File: tb/tb_verilog_literal_emitter.sv
// Bench for verilog_literal_emitter: string-level model plus
// hand-written literals for directed requests.
module tb_verilog_literal_emitter;

  localparam int WD = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  verilog_literal_emitter_if #(.W_DATA(WD)) bus ();

  verilog_literal_emitter #(.W_DATA(WD)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  typedef struct {
    logic [7:0] ch;
    logic       last;
  } exp_t;

  exp_t  q[$];
  exp_t  e_c;
  string got;
  bit    lit_done;
  int    nfire  = 0;
  int    checks = 0;
  int    errors = 0;

  task automatic check(string name, bit ok, string act, string exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %s want %s", name, act, exp);
    end
  endtask

  function automatic string model(logic [63:0] v, int width,
                                  logic [1:0] base, bit sgn);
    int w, k, d;
    logic [63:0] m;
    logic [3:0] dg;
    string s, sg, bl;
    w = (width == 0 || width > WD) ? WD : width;
    k = (base == 2'd0) ? 1 : (base == 2'd1) ? 3 : 4;
    d = (w + k - 1) / k;
    m = (w == 64) ? v : (v & ((64'd1 << w) - 64'd1));
    if (sgn) sg = "s"; else sg = "";
    if (base == 2'd0) bl = "b";
    else if (base == 2'd1) bl = "o";
    else bl = "h";
    s = $sformatf("%0d'%s%s", w, sg, bl);
    for (int i = d - 1; i >= 0; i--) begin
      dg = 4'((m >> (i * k)) & ((64'd1 << k) - 64'd1));
      s = {s, $sformatf("%h", dg)};
`ifdef VERILOG_LITERAL_SEP_EN
      if (i > 0 && i % 4 == 0) s = {s, "_"};
`endif
    end
    return s;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      check("handshake",
            {bus.o_ready, bus.o_busy, bus.o_char_valid} ==
            ((q.size() != 0) ? 3'b011 : 3'b100),
            $sformatf("%b", {bus.o_ready, bus.o_busy, bus.o_char_valid}),
            $sformatf("%b", (q.size() != 0) ? 3'b011 : 3'b100));
      if (bus.o_char_valid && bus.i_char_ready) begin
        nfire++;
        check("expected char pending", q.size() != 0,
              $sformatf("%c", bus.o_char), "none");
        if (q.size() != 0) begin
          e_c = q.pop_front();
          check("char", bus.o_char == e_c.ch && bus.o_char_last == e_c.last,
                $sformatf("%c last=%b", bus.o_char, bus.o_char_last),
                $sformatf("%c last=%b", e_c.ch, e_c.last));
        end
        got = {got, $sformatf("%c", bus.o_char)};
        if (bus.o_char_last) lit_done = 1'b1;
      end
    end
  end

  task automatic start(logic [63:0] v, int width, logic [1:0] base,
                       bit sgn, bit hold);
    string s;
    int t;
    t = 0;
    while (!bus.o_ready && t < 200) begin
      @(posedge clk); #1; t++;
    end
    check("ready before request", bus.o_ready,
          $sformatf("%b", bus.o_ready), "1");
    bus.i_value  = v;
    bus.i_width  = 7'(width);
    bus.i_base   = base;
    bus.i_signed = sgn;
    bus.i_valid  = 1'b1;
    s = model(v, width, base, sgn);
    got = "";
    lit_done = 1'b0;
    @(posedge clk);
    for (int i = 0; i < s.len(); i++)
      q.push_back('{ch: s[i], last: (i == s.len() - 1)});
    #1;
    if (hold) begin
      bus.i_value  = ~v;
      bus.i_width  = 7'd3;
      bus.i_base   = 2'd0;
      bus.i_signed = ~sgn;
      repeat (3) @(posedge clk);
      #1;
    end
    bus.i_valid = 1'b0;
  endtask

  task automatic finish_lit(string name, string lit);
    for (int t = 0; t < 400 && !lit_done; t++) begin
      @(posedge clk); #1;
    end
    check({name, " completes"}, lit_done,
          $sformatf("%b", lit_done), "1");
    if (lit.len() > 0) check(name, got == lit, got, lit);
  endtask

  string l48, lb8, l64, l10, ldead, l9;
  int n0;

  initial begin
`ifdef VERILOG_LITERAL_SEP_EN
    l48   = "48'h1234_abcd_ef69";
    lb8   = "8'b1100_0011";
    l64   = "64'h0000_0000_0000_0001";
    l10   = "10'b10_1010_0101";
    ldead = "64'hdead_beef_0123_4567";
    l9    = "9'sb0_0101_1010";
`else
    l48   = "48'h1234abcdef69";
    lb8   = "8'b11000011";
    l64   = "64'h0000000000000001";
    l10   = "10'b1010100101";
    ldead = "64'hdeadbeef01234567";
    l9    = "9'sb001011010";
`endif
    bus.i_valid      = 1'b0;
    bus.i_value      = '0;
    bus.i_width      = '0;
    bus.i_base       = 2'd0;
    bus.i_signed     = 1'b0;
    bus.i_char_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("reset o_ready", bus.o_ready == 1'b1,
          $sformatf("%b", bus.o_ready), "1");
    check("reset o_char_valid", bus.o_char_valid == 1'b0,
          $sformatf("%b", bus.o_char_valid), "0");
    check("reset o_char", bus.o_char == 8'h00,
          $sformatf("%h", bus.o_char), "00");
    check("reset o_char_last", bus.o_char_last == 1'b0,
          $sformatf("%b", bus.o_char_last), "0");
    check("reset o_busy", bus.o_busy == 1'b0,
          $sformatf("%b", bus.o_busy), "0");
    rst = 1'b0;
    @(posedge clk); #1;

    start(64'h3f, 8, 2'd2, 1'b1, 1'b0);
    finish_lit("hex8 signed", "8'sh3f");

    start(64'h1234abcdef69, 48, 2'd2, 1'b0, 1'b1);
    finish_lit("hex48", l48);

    start(64'hc3, 8, 2'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.i_char_ready = 1'b0;
    check("bp tick shown", bus.o_char == 8'h27 && bus.o_char_valid,
          $sformatf("%c v=%b", bus.o_char, bus.o_char_valid), "' v=1");
    repeat (3) begin
      @(posedge clk); #1;
      check("bp tick held",
            bus.o_char == 8'h27 && bus.o_char_valid && !bus.o_char_last,
            $sformatf("%c v=%b", bus.o_char, bus.o_char_valid), "' v=1");
    end
    bus.i_char_ready = 1'b1;
    finish_lit("bin8 backpressure", lb8);

    start(64'hff, 5, 2'd1, 1'b0, 1'b0);
    finish_lit("oct5 masked", "5'o37");

    start(64'h1, 0, 2'd2, 1'b0, 1'b0);
    finish_lit("width0 clamp", l64);

    start(64'h2a5, 10, 2'd0, 1'b0, 1'b0);
    finish_lit("bin10", l10);

    start(64'hdeadbeef01234567, 100, 2'd3, 1'b0, 1'b0);
    finish_lit("width100 base3", ldead);

    start(64'h5a5a, 9, 2'd0, 1'b1, 1'b0);
    finish_lit("bin9 signed", l9);

    start(64'h1, 1, 2'd0, 1'b0, 1'b0);
    finish_lit("bin1", "1'b1");

    start(64'hfedcba9876543210, 64, 2'd1, 1'b1, 1'b0);
    finish_lit("oct64 signed", "");

    n0 = nfire;
    start(64'hbeef, 16, 2'd2, 1'b0, 1'b0);
    for (int t = 0; t < 50 && nfire < n0 + 5; t++) begin
      @(posedge clk); #1;
    end
    check("reached digits", nfire >= n0 + 5,
          $sformatf("%0d", nfire - n0), ">=5");
    rst = 1'b1;
    #1;
    check("reset drops valid",
          !bus.o_char_valid && !bus.o_char_last && bus.o_ready,
          $sformatf("v=%b l=%b r=%b", bus.o_char_valid,
                    bus.o_char_last, bus.o_ready), "v=0 l=0 r=1");
    q.delete();
    got = "";
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("ready after reset", bus.o_ready && !bus.o_char_valid,
          $sformatf("r=%b v=%b", bus.o_ready, bus.o_char_valid),
          "r=1 v=0");
    @(posedge clk); #1;
    start(64'h5, 3, 2'd0, 1'b0, 1'b0);
    finish_lit("after reset", "3'b101");

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/verilog_literal_emitter.md
# verilog_literal_emitter

Hardware formatter that turns a binary value into the ASCII text of a sized Verilog-based literal, for example `48'h1234_abcd_ef69`, `8'sb1100_0011` or `5'o37`. It is the emitting counterpart of the literal lexer in the Verilog front end. It sits between a value source, such as a debug/trace capture or constant dump, and a byte-wide character sink such as a UART or log FIFO. One request is accepted at a time and streamed out one character per cycle under valid/ready backpressure.

## Interface
- `W_DATA`, default 32: maximum value width in bits; legal range 2..64.
- `W_LEN`, localparam `$clog2(W_DATA+1)`: width of the length field.
- `i_clk` in 1: clock; all logic on the rising edge.
- `i_reset` in 1: reset; asynchronous, active-high.
- `i_valid` in 1: request valid.
- `o_ready` out 1: request accepted on `i_valid && o_ready`; high only in IDLE.
- `i_value` in `W_DATA`: value to format; bits at or above the effective width are ignored.
- `i_width` in `W_LEN`: significant bits. 0 or greater than `W_DATA` is clamped to `W_DATA`.
- `i_base` in 2: 0 = `b`, 1 = `o`, 2 = `h`, 3 = `h`.
- `i_signed` in 1: emit `s` before the base letter.
- `o_char_valid` out 1: character valid.
- `i_char_ready` in 1: sink accepts the character.
- `o_char` out 8: ASCII character.
- `o_char_last` out 1: marks the final character of the literal.
- `o_busy` out 1: high from accept until the last character is taken.

## Operation
- Reset values:
  - `o_ready`=1
  - `o_char_valid`=0
  - `o_char`=8'h00
  - `o_char_last`=0
  - `o_busy`=0
  - state IDLE
- On accept, capture value, clamped width `w`, base and signed flag. Compute:
  - `k` = 1, 3 or 4 for base `b`, `o` or `h`.
  - digit count `D = ceil(w/k)`.
- States, in order: IDLE → SIZE_T → SIZE_O → TICK → SGN → BASE → DIGIT ⇄ SEP → IDLE.
  - SIZE_T emits the tens digit of `w`; it is skipped when `w < 10`.
  - SIZE_O emits the ones digit of `w`.
  - TICK emits `'`.
  - SGN emits `s`; it is skipped when the captured signed flag is 0.
  - BASE emits `b`, `o` or `h`.
  - DIGIT emits digit index `i`, counting from `D-1` down to 0.
  - SEP emits `_`.
- Digit `i` = `(value >> i*k) & (2^k-1)`, with bits at position `w` or above forced to 0.
- Digits are always emitted: leading zeros are kept, so the output is exactly `D` digits. Hex digits are lower-case `a`–`f`.
- After digit `i` is accepted, go to SEP when `i > 0` and `i % 4 == 0`; otherwise go to the next digit. Grouping is counted from the LSB.
- `o_char_last` = 1 only with digit index 0.
- A state advances only on `o_char_valid && i_char_ready`.

## Timing
- Request accepted at edge N: `o_char_valid`=1 with the first character from N+1.
- Throughput is 1 char/cycle while `i_char_ready`=1, with no bubbles between states.
- Backpressure: while `o_char_valid && !i_char_ready`, `o_char` and `o_char_last` hold stable.
- Last character accepted at edge M: `o_char_valid`=0 and `o_ready`=1 from M+1. There is no back-to-back overlap.
- `i_valid` is ignored while `o_ready`=0. Input fields are sampled only at accept.
- `i_reset` asserted mid-stream immediately deasserts `o_char_valid`. The partial literal is abandoned with no `o_char_last`, and the block returns to IDLE.

## Configuration
- `VERILOG_LITERAL_SEP_EN` defined: SEP state and `_` insertion every 4 digits, as described above.
- Not defined: SEP state absent. Digits are emitted contiguously and total length drops by `floor((D-1)/4)`.

## Structure
- Package `verilog_lit_pkg` holds:
  - the state enum;
  - base encodings `BASE_B`/`BASE_O`/`BASE_H`;
  - ASCII constants for `'`, `_`, `s`, `b`, `o`, `h`;
  - function `nibble_to_ascii`.
- One sub-module, `lit_digit_sel`: combinational extraction of digit `i` with width masking, parameterised by `W_DATA`.
- The top level holds the FSM, digit counter and output register.

## Test plan
- **Hex, signed, 8 bits:** `W_DATA`=64, `i_width`=8, hex, signed, value 0x3f → `8'sh3f` (6 chars); `o_char_last` on `f`.
- **Hex with separators:** `i_width`=48, hex, value 0x1234abcdef69, macro on → `48'h1234_abcd_ef69`. Macro off → `48'h1234abcdef69`.
- **Binary and octal:**
  - `i_width`=8, binary, value 0xc3 → `8'b1100_0011`.
  - `i_width`=5, octal, value 0xff → `5'o37` (bits 5–7 masked).
- **Width clamp and leading zeros:** `i_width`=0, hex, value 0x1 → `64'h0000_0000_0000_0001`.
- **Backpressure:** hold `i_char_ready` low 3 cycles on the `'` character → `o_char` is stable for those 3 cycles and the stream resumes without loss or duplication.
- **Reset mid-stream:** assert `i_reset` during DIGIT → `o_char_valid`=0 immediately and `o_ready`=1 after release; the next request `3'b101` → `3'b101`.
